// File: rtl/noc_pkg.sv
// Shared types and constants for the tree NoC merge path.
package noc_pkg;

  // Flit layout: [8:5] address, [4:0] payload.
  localparam int unsigned FLIT_W  = 9;
  localparam int unsigned ADDR_HI = 8;
  localparam int unsigned ADDR_LO = 5;

  typedef logic [FLIT_W-1:0] flit_t;

  // FIFO entry: flit plus the input it came from.
  typedef struct packed {
    logic  sel;
    flit_t data;
  } tagged_flit_t;

endpackage

// File: rtl/noc_rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational; the last-grant state
// lives in the caller so that it only advances on an accepted push.
module noc_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Grant the lone requester, or the one that did not win last time.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = 1'b0;
    unique case (req_i)
      2'b01: begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = 1'b0;
      end
      2'b10: begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = 1'b1;
      end
      2'b11: begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = ~last_grant_i;
      end
      default: begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/noc_merge2.sv
// 2-to-1 merge for the tree NoC: round-robin arbitration between two
// valid/ready inputs into a small output FIFO. Each buffered flit carries
// a source tag (0 = in0, 1 = in1).
// Optional build macro NOC_MERGE_STATS_EN adds saturating per-input grant
// counters; the datapath is identical with or without it.
module noc_merge2
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
`ifdef NOC_MERGE_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in0_valid_i,
  input  logic [FLIT_W-1:0] in0_data_i,
  output logic              in0_ready_o,
  input  logic              in1_valid_i,
  input  logic [FLIT_W-1:0] in1_data_i,
  output logic              in1_ready_o,
  output logic              out_valid_o,
  output logic [FLIT_W-1:0] out_data_o,
  output logic              out_sel_o,
  input  logic              out_ready_i
`ifdef NOC_MERGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0_o,
  output logic [CNT_W-1:0]  grant_cnt1_o
`endif
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntBits = $clog2(DEPTH) + 1;

  localparam logic [PtrW-1:0]    PtrOne  = PtrW'(1);
  localparam logic [CntBits-1:0] CntOne  = CntBits'(1);
  localparam logic [CntBits-1:0] CntFull = CntBits'(DEPTH);

  tagged_flit_t       mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntBits-1:0] count_q, count_d;
  logic               last_grant_q, last_grant_d;

  logic         gnt_valid;
  logic         gnt_idx;
  logic         full;
  logic         pop;
  logic         push_ok;
  logic         push;
  tagged_flit_t head;
  tagged_flit_t wr_entry;

  noc_rr_arb2 u_arb (
    .req_i        ({in1_valid_i, in0_valid_i}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  // Handshake decode; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    full        = (count_q == CntFull);
    out_valid_o = (count_q != '0);
    pop         = out_valid_o && out_ready_i;
    push_ok     = !full || pop;
    push        = gnt_valid && push_ok;
    // No acceptance while held in reset.
    in0_ready_o = rst_ni && push_ok && gnt_valid && !gnt_idx;
    in1_ready_o = rst_ni && push_ok && gnt_valid && gnt_idx;
  end

  // Entry written on push: winning input's flit tagged with its index.
  always_comb begin
    wr_entry.sel  = gnt_idx;
    wr_entry.data = gnt_idx ? in1_data_i : in0_data_i;
  end

  // Head of the FIFO drives the output straight from storage.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_data_o = head.data;
    out_sel_o  = head.sel;
  end

  // Pointer, occupancy and arbitration-history next state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + PtrOne;
      last_grant_d = gnt_idx;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Control state; last_grant resets to 1 so in0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

`ifdef NOC_MERGE_STATS_EN
  localparam logic [CNT_W-1:0] StatOne = CNT_W'(1);

  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

  // Saturating per-input push counters.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (push && !gnt_idx && (grant_cnt0_q != '1)) begin
      grant_cnt0_d = grant_cnt0_q + StatOne;
    end
    if (push && gnt_idx && (grant_cnt1_q != '1)) begin
      grant_cnt1_d = grant_cnt1_q + StatOne;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0_o = grant_cnt0_q;
  assign grant_cnt1_o = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_noc_merge2.sv
// Directed self-checking bench for noc_merge2 (DEPTH = 2).
`timescale 1ns/1ps
module tb_noc_merge2;
  import noc_pkg::*;

  logic              clk;
  logic              rst_ni;
  logic              in0_valid;
  logic [FLIT_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [FLIT_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [FLIT_W-1:0] out_data;
  logic              out_sel;
  logic              out_ready;
`ifdef NOC_MERGE_STATS_EN
  localparam int unsigned TbCntW = 2;
  logic [TbCntW-1:0] grant_cnt0;
  logic [TbCntW-1:0] grant_cnt1;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  noc_merge2 #(
    .DEPTH (2)
`ifdef NOC_MERGE_STATS_EN
    ,
    .CNT_W (TbCntW)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in0_valid_i (in0_valid),
    .in0_data_i  (in0_data),
    .in0_ready_o (in0_ready),
    .in1_valid_i (in1_valid),
    .in1_data_i  (in1_data),
    .in1_ready_o (in1_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel),
    .out_ready_i (out_ready)
`ifdef NOC_MERGE_STATS_EN
    ,
    .grant_cnt0_o (grant_cnt0),
    .grant_cnt1_o (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_ni    = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 9'h000) $display("FAIL reset_out_data: got %h want 000", out_data);
    else pass_cnt++;
    total_cnt++;
    if (out_sel !== 1'b0) $display("FAIL reset_out_sel: got %0b want 0", out_sel);
    else pass_cnt++;
    #1 rst_ni = 1'b1;
    #1;
    total_cnt++;
    if ({in1_ready, in0_ready} !== 2'b00)
      $display("FAIL idle_ready: got %b want 00", {in1_ready, in0_ready});
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 9'h0A5;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if ({in1_ready, in0_ready} !== 2'b01)
      $display("FAIL single_ready: got %b want 01", {in1_ready, in0_ready});
    else pass_cnt++;
    step();
    in0_valid = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 9'h0A5})
      $display("FAIL single_out: got v=%0b s=%0b d=%h want v=1 s=0 d=0a5",
               out_valid, out_sel, out_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL single_drain: got %0b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic [FLIT_W-1:0] exp_d;
    logic              exp_s;
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 9'h101;
    in1_valid = 1'b1;
    in1_data  = 9'h1FE;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_s = (k % 2 == 1);
      exp_d = exp_s ? 9'h1FE : 9'h101;
      #1;
      total_cnt++;
      if ({in1_ready, in0_ready} !== {exp_s, ~exp_s})
        $display("FAIL fair_ready[%0d]: got %b want %b", k, {in1_ready, in0_ready},
                 {exp_s, ~exp_s});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({out_valid, out_sel, out_data} !== {1'b1, exp_s, exp_d})
        $display("FAIL fair_out[%0d]: got v=%0b s=%0b d=%h want v=1 s=%0b d=%h", k,
                 out_valid, out_sel, out_data, exp_s, exp_d);
      else pass_cnt++;
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    out_ready = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 9'h1C1;
    #1;
    total_cnt++;
    if (in1_ready !== 1'b1) $display("FAIL bp_accept0: got %0b want 1", in1_ready);
    else pass_cnt++;
    step();
    in1_data = 9'h1C2;
    #1;
    total_cnt++;
    if (in1_ready !== 1'b1) $display("FAIL bp_accept1: got %0b want 1", in1_ready);
    else pass_cnt++;
    step();
    in1_data = 9'h1C3;
    #1;
    total_cnt++;
    if (in1_ready !== 1'b0) $display("FAIL bp_full: got %0b want 0", in1_ready);
    else pass_cnt++;
    total_cnt++;
    if ({out_sel, out_data} !== {1'b1, 9'h1C1})
      $display("FAIL bp_head: got s=%0b d=%h want s=1 d=1c1", out_sel, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in1_ready !== 1'b1) $display("FAIL bp_pop_push_ready: got %0b want 1", in1_ready);
    else pass_cnt++;
    step();
    out_ready = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, in1_ready} !== 2'b10)
      $display("FAIL bp_still_full: got v=%0b r=%0b want v=1 r=0", out_valid, in1_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 9'h1C2) $display("FAIL bp_head2: got %h want 1c2", out_data);
    else pass_cnt++;
    in1_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, 9'h1C3})
      $display("FAIL bp_head3: got v=%0b d=%h want v=1 d=1c3", out_valid, out_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got %0b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [FLIT_W-1:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    in0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_d    = 9'h011 + 9'(k);
      in0_data = exp_d;
      step();
      total_cnt++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, exp_d})
        $display("FAIL wrap_in0[%0d]: got v=%0b s=%0b d=%h want v=1 s=0 d=%h", k,
                 out_valid, out_sel, out_data, exp_d);
      else pass_cnt++;
    end
    in0_data  = 9'h014;
    in1_valid = 1'b1;
    in1_data  = 9'h1E0;
    #1;
    total_cnt++;
    if ({in1_ready, in0_ready} !== 2'b10)
      $display("FAIL wrap_contend: got %b want 10", {in1_ready, in0_ready});
    else pass_cnt++;
    step();
    in1_valid = 1'b0;
    total_cnt++;
    if ({out_sel, out_data} !== {1'b1, 9'h1E0})
      $display("FAIL wrap_out1: got s=%0b d=%h want s=1 d=1e0", out_sel, out_data);
    else pass_cnt++;
    step();
    in0_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 9'h014})
      $display("FAIL wrap_out0: got v=%0b s=%0b d=%h want v=1 s=0 d=014",
               out_valid, out_sel, out_data);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 9'h0A1;
    step();
    in0_data = 9'h0A2;
    step();
    in0_valid = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, 9'h0A1})
      $display("FAIL mid_buffered: got v=%0b d=%h want v=1 d=0a1", out_valid, out_data);
    else pass_cnt++;
    #2 rst_ni = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, out_data} !== {1'b0, 9'h000})
      $display("FAIL mid_async_clear: got v=%0b d=%h want v=0 d=000", out_valid, out_data);
    else pass_cnt++;
    #1 rst_ni = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 9'h033;
    in1_valid = 1'b1;
    in1_data  = 9'h1CC;
    #1;
    total_cnt++;
    if ({in1_ready, in0_ready} !== 2'b01)
      $display("FAIL mid_first_grant: got %b want 01", {in1_ready, in0_ready});
    else pass_cnt++;
    step();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 9'h033})
      $display("FAIL mid_out: got v=%0b s=%0b d=%h want v=1 s=0 d=033",
               out_valid, out_sel, out_data);
    else pass_cnt++;
  endtask

`ifdef NOC_MERGE_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 9'h055;
    step();
    step();
    total_cnt++;
    if (grant_cnt0 !== 2'd2) $display("FAIL stats_cnt0_mid: got %0d want 2", grant_cnt0);
    else pass_cnt++;
    step();
    step();
    step();
    in0_valid = 1'b0;
    total_cnt++;
    if (grant_cnt0 !== 2'd3) $display("FAIL stats_cnt0_sat: got %0d want 3", grant_cnt0);
    else pass_cnt++;
    total_cnt++;
    if (grant_cnt1 !== 2'd0) $display("FAIL stats_cnt1: got %0d want 0", grant_cnt1);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back_full();
    test_wrap();
    test_reset_mid();
`ifdef NOC_MERGE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/noc_merge2.md
Name: noc_merge2

Overview:
- Upward/merge counterpart of the 1-to-2 address decoder in the tree NoC.
- Accepts 9-bit flits on two input channels and arbitrates between them round-robin.
- Buffers winning flits in a small output FIFO and emits them on one output channel.
- Each output flit carries a 1-bit source tag, mirroring the decoder's S select.

Parameters:
- FLIT_W, 9, flit width; bits [8:5] are the address, [4:0] the payload.
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous reset, active-low.
- in0_valid  in  1  input 0 holds a flit.
- in0_data  in  FLIT_W  input 0 flit.
- in0_ready  out  1  input 0 flit accepted this cycle.
- in1_valid  in  1  input 1 holds a flit.
- in1_data  in  FLIT_W  input 1 flit.
- in1_ready  out  1  input 1 flit accepted this cycle.
- out_valid  out  1  FIFO head valid.
- out_data  out  FLIT_W  FIFO head flit.
- out_sel  out  1  source of the head flit: 0 = in0, 1 = in1.
- out_ready  in  1  consumer takes the head flit.
- grant_cnt0  out  CNT_W  only with NOC_MERGE_STATS_EN.
- grant_cnt1  out  CNT_W  only with NOC_MERGE_STATS_EN.

Behaviour:
- Handshake is valid/ready. A transfer occurs on a rising clk edge when valid and ready are both 1.
- Senders hold valid and data stable until their transfer. in*_valid must not depend on in*_ready.
- Reset (rst_n=0, asynchronous):
  - FIFO empty: out_valid=0, count=0, read/write pointers 0.
  - out_data and out_sel are 0.
  - last_grant=1, so in0 wins the first contention.
  - Stats counters are 0.
- Push enable: push_ok = !full || (out_valid && out_ready). A push into a full FIFO is allowed when a pop happens in the same cycle; count is then unchanged.
- Arbitration (combinational, from valids and last_grant only, never from ready):
  - Neither input valid: no grant.
  - Exactly one valid: grant it.
  - Both valid: grant !last_grant.
- Ready outputs:
  - in0_ready = push_ok && grant==0.
  - in1_ready = push_ok && grant==1.
  - At most one in*_ready is high per cycle. The path out_ready to in*_ready is combinational.
- On push:
  - Write {grant, in_data[grant]} at wr_ptr, then advance wr_ptr modulo DEPTH.
  - last_grant <= grant. last_grant does not change without a push.
- On pop: advance rd_ptr modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Output timing:
  - out_valid = (count != 0).
  - out_data and out_sel show the head entry combinationally from storage.
- Latency: a flit accepted at edge N is visible on out_* after edge N. Minimum one cycle in to out.
- Throughput: one flit per cycle sustained while out_ready=1.
- Fairness:
  - With both inputs continuously valid and out_ready=1, grants alternate 0,1,0,1...
  - The output is never stalled while a push is possible.
- Flit contents pass through unmodified. Address bits are not inspected.
- Reset asserted mid-operation:
  - Buffered flits are discarded immediately.
  - in*_ready drops in the same cycle (count=0 but arbitration restarts from last_grant=1).

Optional Feature:
- Macro: NOC_MERGE_STATS_EN.
- Defined:
  - grant_cnt0 and grant_cnt1 ports exist.
  - Each increments on a push from its input.
  - Each saturates at 2^CNT_W-1; no wrap.
  - Both reset to 0.
- Undefined: the ports and counters are absent. Datapath behaviour is identical either way.

Decomposition:
- Package noc_pkg:
  - FLIT_W=9, ADDR_HI=8, ADDR_LO=5.
  - typedef logic [FLIT_W-1:0] flit_t.
  - typedef struct packed {logic sel; flit_t data;} tagged_flit_t.
- Sub-module noc_rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational. last_grant is held in noc_merge2.

Test Plan:
- Reset, then in0_valid=1 data=0x0A5 and out_ready=1: in0_ready=1 in cycle 0; cycle 1 shows out_valid=1, out_data=0x0A5, out_sel=0.
- Both inputs valid (in0=0x101, in1=0x1FE) for 4 cycles, out_ready=1: output order in0, in1, in0, in1 with out_sel 0,1,0,1.
- out_ready=0 with in1 streaming: exactly DEPTH=2 flits are accepted, then in1_ready=0 and count=2. With in1_valid still held, raising out_ready pops and pushes in the same cycle: count stays 2, in1_ready=1.
- Only in0 active for 3 flits, then in1 joins: in1 wins the first contention (last_grant=0) and pointers wrap correctly.
- Assert rst_n=0 with 2 flits buffered: out_valid drops asynchronously. After release, the first contention grants in0.
- With NOC_MERGE_STATS_EN, CNT_W=2 and 5 in0 pushes: grant_cnt0=3 (saturated), grant_cnt1=0.
